// File: rtl/gpio_sw_debounce_if.sv
// Switch-conditioning interface: raw pads and interrupt controls in,
// debounced levels, edge strobes and the sticky change flag out.
interface gpio_sw_debounce_if #(
   parameter int unsigned NUM_SW = 16
);
   logic [NUM_SW-1:0] sw_raw_i;
   logic [NUM_SW-1:0] irq_en_i;
   logic              irq_clr_i;
   logic [NUM_SW-1:0] sw_db_o;
   logic [NUM_SW-1:0] sw_rise_o;
   logic [NUM_SW-1:0] sw_fall_o;
   logic              sw_chg_irq_o;

   modport master (
      output sw_raw_i, irq_en_i, irq_clr_i,
      input  sw_db_o, sw_rise_o, sw_fall_o, sw_chg_irq_o
   );

   modport slave (
      input  sw_raw_i, irq_en_i, irq_clr_i,
      output sw_db_o, sw_rise_o, sw_fall_o, sw_chg_irq_o
   );
endinterface

// File: rtl/gpio_sw_debounce.sv
// Per-bit synchroniser and stable-count debouncer for board switches, with
// registered rise/fall strobes and a sticky, maskable change interrupt.
module gpio_sw_debounce #(
   parameter int unsigned NUM_SW          = 16,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input logic               clk,
   input logic               rst,
   gpio_sw_debounce_if.slave bus
);
   localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [NUM_SW-1:0] sync_r [SYNC_STAGES];
   logic [NUM_SW-1:0] sync_q;
   logic [CNT_W-1:0]  cnt    [NUM_SW];
   logic [NUM_SW-1:0] flip;
   logic [NUM_SW-1:0] db_q;
   logic [NUM_SW-1:0] rise_q;
   logic [NUM_SW-1:0] fall_q;
   logic              irq_q;
   logic              irq_set;

   assign sync_q = sync_r[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
            sync_r[s] <= '0;
         end
      end else begin
         sync_r[0] <= bus.sw_raw_i;
         for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
            sync_r[s] <= sync_r[s-1];
         end
      end
   end

   // A bit flips on the mismatch cycle that finds its counter already full.
   always_comb begin
      flip = '0;
      for (int unsigned i = 0; i < NUM_SW; i++) begin
         flip[i] = (sync_q[i] != db_q[i]) && (cnt[i] == CNT_MAX);
      end
   end

   assign irq_set = |((rise_q | fall_q) & bus.irq_en_i);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_SW; i++) begin
            cnt[i] <= '0;
         end
         db_q   <= '0;
         rise_q <= '0;
         fall_q <= '0;
         irq_q  <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < NUM_SW; i++) begin
            if (sync_q[i] == db_q[i] || flip[i]) begin
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end
         end
         db_q   <= db_q ^ flip;
         rise_q <= flip & sync_q;
         fall_q <= flip & ~sync_q;
         if (irq_set) begin
            irq_q <= 1'b1;
         end else if (bus.irq_clr_i) begin
            irq_q <= 1'b0;
         end
      end
   end

   assign bus.sw_db_o      = db_q;
   assign bus.sw_rise_o    = rise_q;
   assign bus.sw_fall_o    = fall_q;
   assign bus.sw_chg_irq_o = irq_q;
endmodule

// File: tb/tb_gpio_sw_debounce.sv
// Self-checking bench for gpio_sw_debounce: table of per-cycle vectors plus
// hand-written bounce, set/clear race and mid-debounce reset sequences.
module tb_gpio_sw_debounce;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_step  = 0;

   always #5 clk = ~clk;

   gpio_sw_debounce_if #(.NUM_SW(16)) bus ();

   gpio_sw_debounce #(
      .NUM_SW(16),
      .SYNC_STAGES(2),
      .DEBOUNCE_CYCLES(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      logic [15:0] raw;
      logic [15:0] en;
      logic        clr;
      logic [15:0] db;
      logic [15:0] rise;
      logic [15:0] fall;
      logic        irq;
      string       tag;
   } vec_t;

   typedef struct {
      logic [15:0] db;
      logic [15:0] rise;
      logic [15:0] fall;
      logic        irq;
      string       tag;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];

   function automatic void add(logic [15:0] raw, logic [15:0] en, logic clr,
                               logic [15:0] db, logic [15:0] rise,
                               logic [15:0] fall, logic irq, string tag);
      vec_t v;
      v.raw = raw; v.en = en; v.clr = clr;
      v.db = db; v.rise = rise; v.fall = fall; v.irq = irq; v.tag = tag;
      tbl.push_back(v);
   endfunction

   function automatic void hold(int n, logic [15:0] raw, logic [15:0] en,
                                logic [15:0] db, string tag);
      for (int k = 0; k < n; k++) add(raw, en, 1'b0, db, '0, '0, 1'b0, tag);
   endfunction

   task automatic cmp16(string name, string tag, logic [15:0] got, logic [15:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s.%s step %0d: got %h, expected %h", tag, name, n_step, got, exp);
      end
   endtask

   task automatic check_out();
      exp_t e;
      if (sb.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL scoreboard step %0d: got empty queue, expected an entry", n_step);
      end else begin
         e = sb.pop_front();
         cmp16("db",   e.tag, bus.sw_db_o,   e.db);
         cmp16("rise", e.tag, bus.sw_rise_o, e.rise);
         cmp16("fall", e.tag, bus.sw_fall_o, e.fall);
         cmp16("irq",  e.tag, {15'd0, bus.sw_chg_irq_o}, {15'd0, e.irq});
      end
   endtask

   task automatic push_exp(logic [15:0] db, logic [15:0] rise, logic [15:0] fall,
                           logic irq, string tag);
      exp_t e;
      e.db = db; e.rise = rise; e.fall = fall; e.irq = irq; e.tag = tag;
      sb.push_back(e);
   endtask

   // Drive one cycle of inputs, then compare outputs just after the edge.
   task automatic step(logic [15:0] raw, logic [15:0] en, logic clr,
                       logic [15:0] db, logic [15:0] rise, logic [15:0] fall,
                       logic irq, string tag);
      bus.sw_raw_i  = raw;
      bus.irq_en_i  = en;
      bus.irq_clr_i = clr;
      push_exp(db, rise, fall, irq, tag);
      @(posedge clk);
      #1;
      n_step++;
      check_out();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [12:0] bounce;
      bus.sw_raw_i  = '0;
      bus.irq_en_i  = '0;
      bus.irq_clr_i = 1'b0;

      hold(3, 16'h0000, 16'h0000, 16'h0000, "idle");
      hold(5, 16'h0008, 16'h0008, 16'h0000, "b3_wait");
      add(16'h0008, 16'h0008, 1'b0, 16'h0008, 16'h0008, 16'h0000, 1'b0, "b3_rise");
      add(16'h0008, 16'h0008, 1'b0, 16'h0008, 16'h0000, 16'h0000, 1'b1, "b3_irq");
      add(16'h0008, 16'h0008, 1'b0, 16'h0008, 16'h0000, 16'h0000, 1'b1, "b3_hold");
      add(16'h0008, 16'h0008, 1'b1, 16'h0008, 16'h0000, 16'h0000, 1'b0, "b3_clr");
      add(16'h0008, 16'h0008, 1'b0, 16'h0008, 16'h0000, 16'h0000, 1'b0, "b3_clr_hold");
      hold(5, 16'h0000, 16'h0000, 16'h0008, "b3f_wait");
      add(16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0008, 1'b0, "b3_fall_noen");
      add(16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, "b3_noirq");
      hold(5, 16'hFFFF, 16'h0000, 16'h0000, "all_wait");
      add(16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, "all_rise");
      add(16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, "all_rise_end");
      hold(5, 16'h0000, 16'h0000, 16'hFFFF, "allf_wait");
      add(16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'hFFFF, 1'b0, "all_fall");
      add(16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, "all_fall_end");

      // reset state
      repeat (2) @(posedge clk);
      #1;
      push_exp('0, '0, '0, 1'b0, "reset");
      check_out();
      rst = 1'b0;

      for (int k = 0; k < tbl.size(); k++) begin
         step(tbl[k].raw, tbl[k].en, tbl[k].clr,
              tbl[k].db, tbl[k].rise, tbl[k].fall, tbl[k].irq, tbl[k].tag);
      end

      // bounce: high 3, low 1, high 3, then low; never reaches 4 stable cycles
      bounce = 13'b1110111000000;
      for (int k = 12; k >= 0; k--) begin
         step({15'd0, bounce[k]}, 16'h0001, 1'b0, '0, '0, '0, 1'b0, "bounce");
      end

      // set wins over a simultaneous clear, enable change keeps flag, clear alone
      for (int k = 0; k < 5; k++)
         step(16'h0001, 16'h0001, 1'b0, 16'h0000, '0, '0, 1'b0, "sc_wait");
      step(16'h0001, 16'h0001, 1'b0, 16'h0001, 16'h0001, '0, 1'b0, "sc_rise");
      step(16'h0001, 16'h0001, 1'b1, 16'h0001, '0, '0, 1'b1, "set_wins");
      step(16'h0001, 16'h0000, 1'b0, 16'h0001, '0, '0, 1'b1, "en_change");
      step(16'h0001, 16'h0000, 1'b1, 16'h0001, '0, '0, 1'b0, "clr_alone");
      step(16'h0001, 16'h0000, 1'b0, 16'h0001, '0, '0, 1'b0, "clr_hold");

      // reset while bit 5 is part-way through its count
      for (int k = 0; k < 4; k++)
         step(16'h0021, 16'h0000, 1'b0, 16'h0001, '0, '0, 1'b0, "pre_rst");
      rst = 1'b1;
      #1;
      push_exp('0, '0, '0, 1'b0, "rst_async");
      check_out();
      @(posedge clk);
      #1;
      push_exp('0, '0, '0, 1'b0, "rst_held");
      check_out();
      rst = 1'b0;
      for (int k = 0; k < 5; k++)
         step(16'h0021, 16'h0020, 1'b0, 16'h0000, '0, '0, 1'b0, "post_rst_wait");
      step(16'h0021, 16'h0020, 1'b0, 16'h0021, 16'h0021, '0, 1'b0, "post_rst_rise");
      step(16'h0021, 16'h0020, 1'b0, 16'h0021, '0, '0, 1'b1, "post_rst_irq");
      step(16'h0021, 16'h0020, 1'b0, 16'h0021, '0, '0, 1'b1, "post_rst_hold");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
